// File: rtl/lisp_defs.sv
// Shared definitions for the heap object fetcher.
// Object layout in heap memory, for a tagged pointer p:
//   p    header  ([15] mark, [14:0] type tag)
//   p-1  data    (number value / car)
//   p-2  link    (link / cdr)
package lisp_defs;

  localparam logic [15:0] LISP_NIL = 16'h0000;

  localparam int HDR_MARK_BIT = 15;
  localparam int HDR_TYPE_MSB = 14;
  localparam logic [15:0] OFS_DATA = 16'd1;
  localparam logic [15:0] OFS_LINK = 16'd2;

  typedef logic [HDR_TYPE_MSB:0] type_tag_t;

  localparam type_tag_t TYPE_NUMBER = 15'd1;
  localparam type_tag_t TYPE_CONS   = 15'd2;
  localparam type_tag_t TYPE_SYMBOL = 15'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_HDR  = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_WAIT_LINK = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_BAD_TYPE = 2'd1,
    ERR_BAD_PTR  = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } fetch_err_t;

  // Only numbers and conses carry a data and a link word worth reading.
  function automatic logic tag_has_body(input logic [15:0] hdr);
    type_tag_t tag;
    tag = hdr[HDR_TYPE_MSB:0];
    return (tag == TYPE_NUMBER) || (tag == TYPE_CONS);
  endfunction

endpackage

// File: rtl/object_fetcher.sv
// object_fetcher: heap read-port initiator that loads a 3-word object.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, ptr               fetch request (taken only when idle)
//   busy, done               fetch in progress / one-cycle completion pulse
//   is_nil, err, err_code    result flags, valid with done, held afterwards
//   header, data0, link      fetched words, held until next accepted start
//   mem_req, mem_addr        one-cycle read request per word
//   mem_data_ready/_out      read response, one cycle after mem_req
// Build option: FETCH_TIMEOUT_EN adds a per-word response watchdog that
// ends the fetch with err_code 3 after TimeoutCycles silent cycles.
module object_fetcher
  import lisp_defs::*;
#(
  parameter int MemorySize    = 256,
  parameter int TimeoutCycles = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] ptr,
  output logic        busy,
  output logic        done,
  output logic        is_nil,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] header,
  output logic [15:0] data0,
  output logic [15:0] link,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_data_ready,
  input  logic [15:0] mem_data_out
);

  localparam logic [16:0] MEM_LIM = 17'(MemorySize);

  fetch_state_t state;
  logic [15:0]  base;

  // Pointer 0/1 would make p-2 wrap, so the low bound is 2.
  logic ptr_bad;
  assign ptr_bad = (ptr < 16'd2) || ({1'b0, ptr} >= MEM_LIM);

`ifdef FETCH_TIMEOUT_EN
  localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TimeoutCycles - 1);
  logic [TW-1:0] tmo_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      base     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      is_nil   <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
      header   <= '0;
      data0    <= '0;
      link     <= '0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
`ifdef FETCH_TIMEOUT_EN
      tmo_cnt  <= '0;
`endif
    end else begin
      // Requests and done are single-cycle pulses.
      mem_req <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            is_nil   <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
            header   <= '0;
            data0    <= '0;
            link     <= '0;
            if (ptr == LISP_NIL) begin
              is_nil <= 1'b1;
              done   <= 1'b1;
            end else if (ptr_bad) begin
              err      <= 1'b1;
              err_code <= ERR_BAD_PTR;
              done     <= 1'b1;
            end else begin
              base     <= ptr;
              mem_req  <= 1'b1;
              mem_addr <= ptr;
              busy     <= 1'b1;
              state    <= ST_WAIT_HDR;
            end
          end
        end
        ST_WAIT_HDR: begin
          if (mem_data_ready) begin
            header <= mem_data_out;
            if (tag_has_body(mem_data_out)) begin
              mem_req  <= 1'b1;
              mem_addr <= base - OFS_DATA;
              state    <= ST_WAIT_DATA;
            end else begin
              err      <= 1'b1;
              err_code <= ERR_BAD_TYPE;
              done     <= 1'b1;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        ST_WAIT_DATA: begin
          if (mem_data_ready) begin
            data0    <= mem_data_out;
            mem_req  <= 1'b1;
            mem_addr <= base - OFS_LINK;
            state    <= ST_WAIT_LINK;
          end
        end
        ST_WAIT_LINK: begin
          if (mem_data_ready) begin
            link  <= mem_data_out;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef FETCH_TIMEOUT_EN
      // Every new request coincides with a response, so clearing on
      // mem_data_ready restarts the count for each word.
      if (state == ST_IDLE || mem_data_ready) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        tmo_cnt  <= '0;
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
        done     <= 1'b1;
        busy     <= 1'b0;
        state    <= ST_IDLE;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_object_fetcher.sv
module tb_object_fetcher;
  import lisp_defs::*;

  localparam int MEMSZ = 256;
  localparam int TMO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] ptr = '0;
  logic busy, done, is_nil, err, mem_req;
  logic [1:0] err_code;
  logic [15:0] header, data0, link, mem_addr;
  logic mem_data_ready = 1'b0;
  logic [15:0] mem_data_out = '0;

  logic [15:0] mem [0:MEMSZ-1];
  logic mute = 1'b0;
  logic noise = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  object_fetcher #(.MemorySize(MEMSZ), .TimeoutCycles(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .ptr(ptr),
    .busy(busy), .done(done), .is_nil(is_nil), .err(err), .err_code(err_code),
    .header(header), .data0(data0), .link(link),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_data_ready(mem_data_ready), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Heap memory: answers one cycle after each request; noise injects
  // unsolicited ready pulses, mute models a dead memory.
  always @(posedge clk) begin
    mem_data_ready <= ((mem_req && !mute) || noise) && !rst;
    mem_data_out   <= noise ? 16'(($urandom)) : mem[mem_addr[7:0]];
  end

  typedef struct {
    logic        is_nil;
    logic        err;
    logic [1:0]  code;
    logic [15:0] hdr;
    logic [15:0] d0;
    logic [15:0] lk;
    logic [15:0] p;
    int          nreq;
    int          lat;
    int          t0;
  } exp_t;

  exp_t exp_q[$];
  logic [15:0] act_addr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: what a fetch of p must produce, straight from the object layout.
  function automatic exp_t model(input logic [15:0] p, input int t0);
    exp_t e;
    logic [14:0] tag;
    e = '{is_nil: 0, err: 0, code: 0, hdr: 0, d0: 0, lk: 0, p: p, nreq: 0, lat: 1, t0: t0};
    if (p == LISP_NIL) begin
      e.is_nil = 1;
    end else if (p < 2 || int'(p) >= MEMSZ) begin
      e.err = 1; e.code = 2;
    end else begin
      e.hdr = mem[p];
      e.nreq = 1;
      e.lat = 3;
      tag = e.hdr[14:0];
      if (tag == TYPE_NUMBER || tag == TYPE_CONS) begin
        e.d0 = mem[p - 1];
        e.lk = mem[p - 2];
        e.nreq = 3;
        e.lat = 7;
      end else begin
        e.err = 1; e.code = 1;
      end
    end
    return e;
  endfunction

  // Monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        act_addr.delete();
      end else begin
        if (mem_req) act_addr.push_back(mem_addr);
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(done), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("is_nil", 32'(is_nil), 32'(e.is_nil));
            chk("err", 32'(err), 32'(e.err));
            chk("err_code", 32'(err_code), 32'(e.code));
            chk("header", 32'(header), 32'(e.hdr));
            chk("data0", 32'(data0), 32'(e.d0));
            chk("link", 32'(link), 32'(e.lk));
            chk("busy_at_done", 32'(busy), 32'd0);
            chk("latency", 32'(cyc - e.t0), 32'(e.lat));
            chk("num_req", 32'(act_addr.size()), 32'(e.nreq));
            for (int i = 0; i < act_addr.size() && i < e.nreq; i++)
              chk("req_addr", 32'(act_addr[i]), 32'(e.p - 16'(i)));
          end
          act_addr.delete();
        end
      end
    end
  end

  task automatic drain();
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      #2;
      if (exp_q.size() == 0) break;
    end
    if (k == 60) begin
      chk("done_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic fetch(input logic [15:0] p);
    @(negedge clk);
    exp_q.push_back(model(p, cyc));
    start = 1'b1;
    ptr = p;
    @(negedge clk);
    start = 1'b0;
    drain();
  endtask

  initial begin
    logic [15:0] p;
    exp_t e;
    int r;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 16'($urandom);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_is_nil", 32'(is_nil), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_code", 32'(err_code), 0);
    chk("rst_header", 32'(header), 0);
    chk("rst_data0", 32'(data0), 0);
    chk("rst_link", 32'(link), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    // Number object
    mem[3] = {1'b0, TYPE_NUMBER};
    mem[2] = 16'h789A;
    mem[1] = LISP_NIL;
    fetch(16'd3);
    // NIL, bad pointers
    fetch(LISP_NIL);
    fetch(16'd1);
    fetch(16'd300);
    fetch(16'hFFFF);
    fetch(16'(MEMSZ));
    // Cons at the lowest legal pointer, with mark bit set
    mem[2] = {1'b1, TYPE_CONS};
    fetch(16'd2);
    // Unfetchable type
    mem[10] = {1'b0, TYPE_SYMBOL};
    fetch(16'd10);
    // Highest legal pointer
    mem[MEMSZ-1] = {1'b0, TYPE_NUMBER};
    fetch(16'(MEMSZ - 1));

    // Unsolicited ready while idle must not produce anything
    noise = 1'b1;
    repeat (8) @(negedge clk);
    noise = 1'b0;
    repeat (3) @(negedge clk);

    // Start pulses while busy are ignored
    mem[20] = {1'b0, TYPE_CONS};
    @(negedge clk);
    exp_q.push_back(model(16'd20, cyc));
    start = 1'b1; ptr = 16'd20;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; ptr = LISP_NIL;
    repeat (4) @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-fetch abandons the fetch without a done pulse
    mem[40] = {1'b0, TYPE_NUMBER};
    @(negedge clk);
    exp_q.push_back(model(16'd40, cyc));
    start = 1'b1; ptr = 16'd40;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    e = exp_q.pop_back();
    @(negedge clk);
    #1;
    chk("midrst_mem_req", 32'(mem_req), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    fetch(16'd40);

    // Randomized fetches
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) p = LISP_NIL;
      else if (r == 1) p = 16'($urandom_range(0, 1));
      else if (r == 2) p = 16'($urandom_range(MEMSZ, 65535));
      else begin
        p = 16'($urandom_range(2, MEMSZ - 1));
        r = $urandom_range(0, 9);
        mem[p] = {1'($urandom), (r < 6) ? TYPE_NUMBER : (r < 8) ? TYPE_CONS : 15'($urandom)};
      end
      fetch(p);
    end

`ifdef FETCH_TIMEOUT_EN
    // Silent memory: watchdog ends the fetch
    mem[50] = {1'b0, TYPE_NUMBER};
    mute = 1'b1;
    @(negedge clk);
    e = '{is_nil: 0, err: 1, code: 3, hdr: 0, d0: 0, lk: 0, p: 16'd50, nreq: 1, lat: TMO + 1, t0: cyc};
    exp_q.push_back(e);
    start = 1'b1; ptr = 16'd50;
    @(negedge clk);
    start = 1'b0;
    drain();
    mute = 1'b0;
    fetch(16'd50);
`endif

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
